scanchain_master: RTL and testbench

SCANCHAIN_MASTER -- requirements
Module: scanchain_master

---
 rtl/scanchain_pkg.sv | 21 ++
 rtl/scanchain_master_scan_clk_gen.sv | 50 +++++
 rtl/scanchain_master.sv | 154 +++++++++++++++
 tb/tb_scanchain_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanchain_pkg.sv
// Shared types and frame-geometry helpers for the scan-chain master.
package scanchain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

    function automatic int frame_len(input int addr_bits, input int payload_bits);
        return addr_bits + payload_bits;
    endfunction

    // Width needed to index 0..n-1, never below one bit.
    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scanchain_master_scan_clk_gen.sv
// Half-period divider: produces scan_clk and one-cycle-early rise/fall strobes.
module scan_clk_gen #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [DIV_BITS-1:0] i_div,
    output logic                o_scan_clk,
    output logic                o_rise,
    output logic                o_fall
);

    logic                r_run;
    logic                r_clk;
    logic [DIV_BITS-1:0] r_div;
    logic [DIV_BITS-1:0] r_cnt;
    logic                w_term;

    // Strobes flag that scan_clk toggles on the coming clk edge.
    assign w_term     = r_run && (r_cnt == r_div);
    assign o_rise     = w_term && !r_clk;
    assign o_fall     = w_term && r_clk;
    assign o_scan_clk = r_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
            r_clk <= 1'b0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_stop) begin
            r_run <= 1'b0;
            r_clk <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_clk <= 1'b0;
            r_div <= i_div;
            r_cnt <= DIV_BITS'(1);
        end else if (w_term) begin
            r_clk <= ~r_clk;
            r_cnt <= DIV_BITS'(1);
        end else if (r_run) begin
            r_cnt <= r_cnt + DIV_BITS'(1);
        end
    end

endmodule

// File: rtl/scanchain_master.sv
// Serial scan-chain master: shifts an addr+payload frame out on a shared
// scan_clk/scan_in and captures the selected chain's return data.
module scanchain_master
    import scanchain_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169,
    parameter int NUM_CHAINS   = 4,
    parameter int DIV_BITS     = 16,
    localparam int N           = frame_len(ADDR_BITS, PAYLOAD_BITS),
    localparam int CHW         = idx_bits(NUM_CHAINS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_BITS-1:0]    req_addr,
    input  logic [PAYLOAD_BITS-1:0] req_payload,
    input  logic                    req_reset,
    input  logic [CHW-1:0]          req_chain,
    input  logic [DIV_BITS-1:0]     req_div,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    scan_clk,
    output logic                    scan_in,
    output logic [NUM_CHAINS-1:0]   scan_en,
    output logic [NUM_CHAINS-1:0]   scan_reset,
    input  logic [NUM_CHAINS-1:0]   scan_out
);

    localparam int BW = idx_bits(N);
    localparam logic [CHW:0] NC_L = (CHW+1)'(NUM_CHAINS);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [N-1:0]          r_cap;
    logic [N-1:0]          r_shift;
    logic [BW-1:0]         r_bits;
    logic                  r_scan_in;
    logic [NUM_CHAINS-1:0] r_en;
    logic [NUM_CHAINS-1:0] r_rst;

    logic                  w_accept;
    logic                  w_chain_ok;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_last;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_sample;
    logic [DIV_BITS-1:0]   w_div;
    logic [NUM_CHAINS-1:0] w_onehot;

    assign w_accept   = req_valid && r_req_ready;
    assign w_chain_ok = {1'b0, req_chain} < NC_L;
    assign w_start    = w_accept && w_chain_ok;
    assign w_div      = (req_div < DIV_BITS'(MIN_DIV)) ? DIV_BITS'(MIN_DIV) : req_div;
    assign w_onehot   = NUM_CHAINS'(1) << req_chain;
    assign w_last     = w_fall && (r_bits == BW'(N-1));
    assign w_stop     = (r_state == ST_SHIFT) && w_last;
    // r_en is one-hot on the active chain, so this selects its return bit.
    assign w_sample   = |(scan_out & r_en);

    scan_clk_gen #(
        .DIV_BITS(DIV_BITS)
    ) u_clk_gen (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_start),
        .i_stop     (w_stop),
        .i_div      (w_div),
        .o_scan_clk (scan_clk),
        .o_rise     (w_rise),
        .o_fall     (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cap       <= '0;
            r_shift     <= '0;
            r_bits      <= '0;
            r_scan_in   <= 1'b0;
            r_en        <= '0;
            r_rst       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_cap       <= '0;
                        if (w_chain_ok) begin
                            r_state   <= ST_SHIFT;
                            r_shift   <= {req_addr, req_payload};
                            r_scan_in <= req_addr[ADDR_BITS-1];
                            r_en      <= w_onehot;
                            r_rst     <= req_reset ? w_onehot : '0;
                            r_bits    <= '0;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_rise)
                        r_cap <= {r_cap[N-2:0], w_sample};
                    if (w_fall) begin
                        if (w_last) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_en        <= '0;
                            r_rst       <= '0;
                        end else begin
                            r_bits    <= r_bits + BW'(1);
                            r_shift   <= r_shift << 1;
                            r_scan_in <= r_shift[N-2];
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_data   = r_cap;
    assign scan_in    = r_scan_in;
    assign scan_en    = r_en;
    assign scan_reset = r_rst;

endmodule

// File: tb/tb_scanchain_master.sv
// Scoreboard bench for scanchain_master with a small 4+8 bit frame.
module tb_scanchain_master;

    localparam int AB = 4;
    localparam int PB = 8;
    localparam int NC = 3;
    localparam int DB = 16;
    localparam int N  = AB + PB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AB-1:0] req_addr = '0;
    logic [PB-1:0] req_payload = '0;
    logic          req_reset = 1'b0;
    logic [1:0]    req_chain = '0;
    logic [DB-1:0] req_div = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [N-1:0]  rsp_data;
    logic          rsp_err;
    logic          scan_clk;
    logic          scan_in;
    logic [NC-1:0] scan_en;
    logic [NC-1:0] scan_reset;
    logic [NC-1:0] scan_out;

    // chain 0 returns 0, chain 1 loops back, chain 2 returns inverted data
    assign scan_out = {~scan_in, scan_in, 1'b0};

    always #5 clk = ~clk;

    scanchain_master #(
        .ADDR_BITS(AB),
        .PAYLOAD_BITS(PB),
        .NUM_CHAINS(NC),
        .DIV_BITS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_payload(req_payload),
        .req_reset(req_reset),
        .req_chain(req_chain),
        .req_div(req_div),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .scan_clk(scan_clk),
        .scan_in(scan_in),
        .scan_en(scan_en),
        .scan_reset(scan_reset),
        .scan_out(scan_out)
    );

    typedef struct {
        logic [N-1:0] data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // response monitor
    logic         p_v = 1'b0;
    logic [N-1:0] p_d = '0;
    logic         p_e = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset && rsp_valid) begin
            if (!p_v) begin
                chk("rsp_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0)
                    chk("rsp_latency", cyc, sb[0].cyc);
            end else begin
                chk("rsp_hold_data", 32'(rsp_data), 32'(p_d));
                chk("rsp_hold_err", 32'(rsp_err), 32'(p_e));
            end
            if (rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        p_v = rsp_valid && !reset;
        p_d = rsp_data;
        p_e = rsp_err;
    end

    // scan-line protocol checker
    int            rises = 0;
    int            viol = 0;
    int            hrun = 0;
    int            exp_d = 2;
    logic          exp_rst_eq = 1'b0;
    logic [N-1:0]  seq = '0;
    logic [NC-1:0] en_or = '0;
    logic [NC-1:0] rst_or = '0;
    logic          q_clk = 1'b0;
    logic          q_in = 1'b0;
    logic          q_rst = 1'b1;
    logic [NC-1:0] q_en = '0;

    initial forever begin
        @(negedge clk);
        if (!reset && !q_rst) begin
            if (scan_in !== q_in && !(q_clk && !scan_clk) && q_en != 0)
                viol++;
            if (scan_clk && !q_clk) begin
                rises++;
                seq = {seq[N-2:0], scan_in};
            end
            if (scan_clk)
                hrun++;
            else if (q_clk) begin
                if (hrun != exp_d)
                    viol++;
                hrun = 0;
            end
            if ((scan_reset & ~scan_en) != 0)
                viol++;
            if (exp_rst_eq && scan_reset != scan_en)
                viol++;
            if (rsp_valid && (scan_en != 0 || scan_reset != 0 || scan_clk))
                viol++;
            en_or  |= scan_en;
            rst_or |= scan_reset;
        end
        q_clk = scan_clk;
        q_in  = scan_in;
        q_en  = scan_en;
        q_rst = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame(input int d, input logic rsteq);
        rises = 0;
        viol = 0;
        hrun = 0;
        seq = '0;
        en_or = '0;
        rst_or = '0;
        exp_d = d;
        exp_rst_eq = rsteq;
    endtask

    task automatic send(input logic [AB-1:0] a, input logic [PB-1:0] p,
                        input logic rr, input logic [1:0] ch, input logic [DB-1:0] div,
                        input logic [N-1:0] ed, input logic ee, input int lat);
        req_addr = a;
        req_payload = p;
        req_reset = rr;
        req_chain = ch;
        req_div = div;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++)
            tick();
        chk("req_ready_at_send", 32'(req_ready), 1);
        sb.push_back('{data: ed, err: ee, cyc: cyc + lat});
        tick();
        req_valid = 1'b0;
        // scramble inputs while the frame is in flight
        req_addr = ~a;
        req_payload = ~p;
        req_reset = ~rr;
        req_chain = ~ch;
        req_div = 16'd7;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < budget) begin
            tick();
            k++;
        end
        chk("done_in_time", 32'(sb.size() == 0 && !rsp_valid), 1);
    endtask

    task automatic frame_checks(input int er, input logic [N-1:0] es,
                                input logic [NC-1:0] een, input logic [NC-1:0] ers);
        chk("scan_rises", rises, er);
        chk("scan_in_seq", 32'(seq), 32'(es));
        chk("scan_en_seen", 32'(en_or), 32'(een));
        chk("scan_reset_seen", 32'(rst_or), 32'(ers));
        chk("scan_protocol", viol, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 0);
        chk("rst_scan", 32'({scan_clk, scan_in, scan_en, scan_reset}), 0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(req_ready), 1);

        // loopback frame, D=2
        clear_frame(2, 1'b0);
        send(4'hA, 8'h5C, 1'b0, 2'd1, 16'd2, 12'hA5C, 1'b0, 49);
        wait_done(200);
        frame_checks(12, 12'hA5C, 3'b010, 3'b000);

        // div 0 clamps to 2
        clear_frame(2, 1'b0);
        send(4'hA, 8'h5C, 1'b0, 2'd1, 16'd0, 12'hA5C, 1'b0, 49);
        wait_done(200);
        frame_checks(12, 12'hA5C, 3'b010, 3'b000);

        // D=3 on chain 0 which returns zeros
        clear_frame(3, 1'b0);
        send(4'h3, 8'hF0, 1'b0, 2'd0, 16'd3, 12'h000, 1'b0, 73);
        wait_done(200);
        frame_checks(12, 12'h3F0, 3'b001, 3'b000);

        // out-of-range chain
        clear_frame(2, 1'b0);
        send(4'hF, 8'hFF, 1'b1, 2'd3, 16'd2, 12'h000, 1'b1, 1);
        wait_done(20);
        frame_checks(0, 12'h000, 3'b000, 3'b000);

        // chain 2 with scan_reset, inverted return
        clear_frame(2, 1'b1);
        send(4'h5, 8'h96, 1'b1, 2'd2, 16'd2, 12'hA69, 1'b0, 49);
        wait_done(200);
        frame_checks(12, 12'h596, 3'b100, 3'b100);

        // response held while rsp_ready low; req_valid pulses ignored
        clear_frame(2, 1'b0);
        rsp_ready = 1'b0;
        send(4'hA, 8'h5C, 1'b0, 2'd1, 16'd2, 12'hA5C, 1'b0, 49);
        for (int i = 0; i < 200 && !rsp_valid; i++)
            tick();
        chk("hold_rsp_seen", 32'(rsp_valid), 1);
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            req_chain = 2'd0;
            req_addr = 4'h1;
            tick();
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done(20);
        frame_checks(12, 12'hA5C, 3'b010, 3'b000);

        // reset mid-frame aborts, then a fresh frame completes
        clear_frame(2, 1'b0);
        send(4'hA, 8'h5C, 1'b0, 2'd1, 16'd2, 12'hA5C, 1'b0, 49);
        for (int i = 0; i < 100 && rises < 5; i++)
            tick();
        chk("abort_reached_bit5", rises, 5);
        reset = 1'b1;
        void'(sb.pop_back());
        tick();
        chk("abort_scan", 32'({scan_clk, scan_in, scan_en, scan_reset}), 0);
        chk("abort_rsp", 32'(rsp_valid), 0);
        reset = 1'b0;
        tick();
        tick();
        clear_frame(2, 1'b0);
        send(4'h6, 8'h3A, 1'b0, 2'd1, 16'd2, 12'h63A, 1'b0, 49);
        wait_done(200);
        frame_checks(12, 12'h63A, 3'b010, 3'b000);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
